inst_fetch_bridge: RTL and testbench

INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

---
 rtl/inst_fetch_bridge_pkg.sv | 19 +
 rtl/inst_addr_map.sv | 17 +
 rtl/inst_fetch_bridge.sv | 143 ++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared CPU package: fetch FSM state encoding, bus size constant and the
// kseg0/kseg1 helper used by the optional address map (INST_ADDR_MAP_EN).
package inst_fetch_bridge_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_ADDR = 2'd1,
        FETCH_DATA = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [1:0] INST_SIZE_WORD = 2'b10;

    // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) together span 0x8000_0000-0xBFFF_FFFF.
    function automatic logic is_kseg01(input logic [31:0] addr);
        return addr[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/inst_addr_map.sv
// Combinational virtual-to-physical map for instruction fetch; only
// instantiated when INST_ADDR_MAP_EN is defined.
module inst_addr_map
    import inst_fetch_bridge_pkg::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if (is_kseg01(vaddr)) begin
            paddr = {3'b000, vaddr[28:0]};
        end
    end

endmodule

// File: rtl/inst_fetch_bridge.sv
// Bridge between the IF stage and an SRAM-like instruction bus with one
// outstanding transaction. Optional macro: INST_ADDR_MAP_EN (kseg0/1 mapping).
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_req_i,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    output logic [31:0] if_instr_o,
    output logic        if_instr_valid_o,
    output logic        if_stall_req_o,
    output logic        inst_req_o,
    output logic        inst_wr_o,
    output logic [1:0]  inst_size_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_wdata_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i
);

    fetch_state_t state_reg;
    logic         discard_reg;
    logic [31:0]  addr_reg;
    logic [31:0]  buffer_reg;
    logic [31:0]  mapped_addr;

    logic launch;
    logic data_hit;
    logic drop;
    logic deliver;

`ifdef INST_ADDR_MAP_EN
    inst_addr_map u_inst_addr_map (
        .vaddr (addr_reg),
        .paddr (mapped_addr)
    );
`else
    assign mapped_addr = addr_reg;
`endif

    assign launch   = (state_reg == FETCH_IDLE) && if_req_i &&
                      (if_pc_i[1:0] == 2'b00) && !if_flush_i;
    assign data_hit = (state_reg == FETCH_DATA) && inst_data_ok_i;
    // A flush arriving with data_ok kills that beat just like an earlier flush.
    assign drop     = discard_reg || if_flush_i;
    assign deliver  = data_hit && !drop;

    assign inst_wr_o    = 1'b0;
    assign inst_size_o  = INST_SIZE_WORD;
    assign inst_wdata_o = 32'h0;

    // Outputs are gated by rst_i so they drop the moment reset asserts.
    always_comb begin
        if_instr_o       = 32'h0;
        if_instr_valid_o = 1'b0;
        if_stall_req_o   = 1'b0;
        inst_req_o       = 1'b0;
        inst_addr_o      = mapped_addr;
        if (rst_i) begin
            inst_addr_o = 32'h0;
        end else begin
            case (state_reg)
                FETCH_IDLE: begin
                    if_stall_req_o = launch;
                end
                FETCH_ADDR: begin
                    if_stall_req_o = 1'b1;
                    inst_req_o     = 1'b1;
                end
                FETCH_DATA: begin
                    if_stall_req_o = !deliver;
                    if (deliver && !if_stall_i) begin
                        if_instr_o       = inst_rdata_i;
                        if_instr_valid_o = 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (!if_flush_i) begin
                        if_instr_o       = buffer_reg;
                        if_instr_valid_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= FETCH_IDLE;
            discard_reg <= 1'b0;
            addr_reg    <= 32'h0;
            buffer_reg  <= 32'h0;
        end else begin
            case (state_reg)
                FETCH_IDLE: begin
                    // Stray data_ok from a pre-reset transaction is ignored here.
                    if (launch) begin
                        addr_reg  <= if_pc_i;
                        state_reg <= FETCH_ADDR;
                    end
                end
                FETCH_ADDR: begin
                    if (if_flush_i) begin
                        discard_reg <= 1'b1;
                    end
                    if (inst_addr_ok_i) begin
                        state_reg <= FETCH_DATA;
                    end
                end
                FETCH_DATA: begin
                    if (inst_data_ok_i) begin
                        discard_reg <= 1'b0;
                        if (drop) begin
                            state_reg <= FETCH_IDLE;
                        end else if (if_stall_i) begin
                            buffer_reg <= inst_rdata_i;
                            state_reg  <= FETCH_HOLD;
                        end else begin
                            state_reg <= FETCH_IDLE;
                        end
                    end else if (if_flush_i) begin
                        discard_reg <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (if_flush_i) begin
                        buffer_reg <= 32'h0;
                        state_reg  <= FETCH_IDLE;
                    end else if (!if_stall_i) begin
                        state_reg <= FETCH_IDLE;
                    end
                end
                default: state_reg <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge; expected bus address
// follows INST_ADDR_MAP_EN.
module tb_inst_fetch_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        if_req_i;
    logic        if_stall_i;
    logic        if_flush_i;
    logic [31:0] if_instr_o;
    logic        if_instr_valid_o;
    logic        if_stall_req_o;
    logic        inst_req_o;
    logic        inst_wr_o;
    logic [1:0]  inst_size_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_wdata_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;

    int checks = 0;
    int errors = 0;

`ifdef INST_ADDR_MAP_EN
    localparam logic [31:0] EXP_BOOT_ADDR = 32'h1FC0_0000;
`else
    localparam logic [31:0] EXP_BOOT_ADDR = 32'hBFC0_0000;
`endif

    always #5 clk_i = ~clk_i;

    inst_fetch_bridge dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .if_pc_i          (if_pc_i),
        .if_req_i         (if_req_i),
        .if_stall_i       (if_stall_i),
        .if_flush_i       (if_flush_i),
        .if_instr_o       (if_instr_o),
        .if_instr_valid_o (if_instr_valid_o),
        .if_stall_req_o   (if_stall_req_o),
        .inst_req_o       (inst_req_o),
        .inst_wr_o        (inst_wr_o),
        .inst_size_o      (inst_size_o),
        .inst_addr_o      (inst_addr_o),
        .inst_wdata_o     (inst_wdata_o),
        .inst_addr_ok_i   (inst_addr_ok_i),
        .inst_data_ok_i   (inst_data_ok_i),
        .inst_rdata_i     (inst_rdata_i)
    );

    // Advance one clock; inputs are then driven after the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic quiet_inputs();
        if_req_i       = 1'b0;
        if_pc_i        = 32'h0;
        if_stall_i     = 1'b0;
        if_flush_i     = 1'b0;
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'h0;
    endtask

    // Launch from IDLE and complete the address phase; returns in DATA.
    task automatic reach_data(input logic [31:0] pc);
        quiet_inputs();
        if_req_i = 1'b1;
        if_pc_i  = pc;
        next_cycle();
        quiet_inputs();
        inst_addr_ok_i = 1'b1;
        next_cycle();
        quiet_inputs();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        quiet_inputs();
        if_req_i = 1'b1;
        if_pc_i  = 32'hBFC0_0000;
        #1;
        checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", if_stall_req_o); end
        checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", inst_req_o); end
        checks++; if (if_instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_instr_valid_o); end
        checks++; if (inst_wr_o !== 1'b0 || inst_size_o !== 2'b10 || inst_wdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_consts got wr=%b size=%b wdata=%h want 0/10/0", inst_wr_o, inst_size_o, inst_wdata_o);
        end
        quiet_inputs();
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        if_req_i = 1'b1;
        if_pc_i  = 32'hBFC0_0000;
        #1;
        checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("FAIL basic_launch_stall got %b want 1", if_stall_req_o); end
        checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL basic_launch_req got %b want 0", inst_req_o); end
        next_cycle();
        quiet_inputs();
        inst_addr_ok_i = 1'b1;
        #1;
        checks++; if (inst_req_o !== 1'b1) begin errors++; $display("FAIL basic_addr_req got %b want 1", inst_req_o); end
        checks++; if (inst_addr_o !== EXP_BOOT_ADDR) begin errors++; $display("FAIL basic_addr got %h want %h", inst_addr_o, EXP_BOOT_ADDR); end
        next_cycle();
        quiet_inputs();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h2408_0001;
        #1;
        checks++; if (if_instr_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", if_instr_valid_o); end
        checks++; if (if_instr_o !== 32'h2408_0001) begin errors++; $display("FAIL basic_instr got %h want 24080001", if_instr_o); end
        checks++; if (if_stall_req_o !== 1'b0) begin errors++; $display("FAIL basic_data_stall got %b want 0", if_stall_req_o); end
        next_cycle();
        quiet_inputs();
        #1;
        checks++; if (if_instr_valid_o !== 1'b0 || inst_req_o !== 1'b0) begin
            errors++; $display("FAIL basic_idle got valid=%b req=%b want 0/0", if_instr_valid_o, inst_req_o);
        end
        $display("test_basic done");
    endtask

    task automatic test_addr_wait();
        if_req_i = 1'b1;
        if_pc_i  = 32'h0040_0010;
        next_cycle();
        quiet_inputs();
        for (int i = 0; i < 4; i++) begin
            inst_addr_ok_i = (i == 3);
            #1;
            checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0040_0010 || if_stall_req_o !== 1'b1) begin
                errors++; $display("FAIL addr_wait_%0d got req=%b addr=%h stall=%b want 1/00400010/1", i, inst_req_o, inst_addr_o, if_stall_req_o);
            end
            next_cycle();
        end
        quiet_inputs();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h0000_1234;
        #1;
        checks++; if (if_instr_valid_o !== 1'b1 || if_instr_o !== 32'h0000_1234) begin
            errors++; $display("FAIL addr_wait_data got valid=%b instr=%h want 1/00001234", if_instr_valid_o, if_instr_o);
        end
        next_cycle();
        quiet_inputs();
        $display("test_addr_wait done");
    endtask

    task automatic test_hold();
        reach_data(32'h0000_0100);
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h1122_3344;
        if_stall_i     = 1'b1;
        #1;
        checks++; if (if_instr_valid_o !== 1'b0 || if_stall_req_o !== 1'b0) begin
            errors++; $display("FAIL hold_capture got valid=%b stall=%b want 0/0", if_instr_valid_o, if_stall_req_o);
        end
        next_cycle();
        quiet_inputs();
        for (int i = 0; i < 2; i++) begin
            if_stall_i = (i == 0);
            #1;
            checks++; if (if_instr_valid_o !== 1'b1 || if_instr_o !== 32'h1122_3344 || if_stall_req_o !== 1'b0) begin
                errors++; $display("FAIL hold_%0d got valid=%b instr=%h stall=%b want 1/11223344/0", i, if_instr_valid_o, if_instr_o, if_stall_req_o);
            end
            next_cycle();
        end
        quiet_inputs();
        #1;
        checks++; if (if_instr_valid_o !== 1'b0) begin errors++; $display("FAIL hold_exit got %b want 0", if_instr_valid_o); end
        $display("test_hold done");
    endtask

    task automatic test_hold_flush();
        reach_data(32'h0000_0200);
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'hCAFE_0001;
        if_stall_i     = 1'b1;
        next_cycle();
        quiet_inputs();
        if_stall_i = 1'b1;
        if_flush_i = 1'b1;
        #1;
        checks++; if (if_instr_valid_o !== 1'b0) begin errors++; $display("FAIL hold_flush got %b want 0", if_instr_valid_o); end
        next_cycle();
        quiet_inputs();
        #1;
        checks++; if (if_instr_valid_o !== 1'b0 || inst_req_o !== 1'b0) begin
            errors++; $display("FAIL hold_flush_idle got valid=%b req=%b want 0/0", if_instr_valid_o, inst_req_o);
        end
        $display("test_hold_flush done");
    endtask

    task automatic test_flush_data();
        reach_data(32'h0000_0300);
        if_flush_i = 1'b1;
        #1;
        checks++; if (if_stall_req_o !== 1'b1) begin errors++; $display("FAIL flush_data_stall got %b want 1", if_stall_req_o); end
        next_cycle();
        quiet_inputs();
        if_req_i = 1'b1;
        if_pc_i  = 32'h0000_0400;
        #1;
        checks++; if (inst_req_o !== 1'b0 || if_instr_valid_o !== 1'b0 || if_stall_req_o !== 1'b1) begin
            errors++; $display("FAIL flush_wait got req=%b valid=%b stall=%b want 0/0/1", inst_req_o, if_instr_valid_o, if_stall_req_o);
        end
        next_cycle();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'hDEAD_BEEF;
        #1;
        checks++; if (if_instr_valid_o !== 1'b0 || if_stall_req_o !== 1'b1) begin
            errors++; $display("FAIL flush_discard got valid=%b stall=%b want 0/1", if_instr_valid_o, if_stall_req_o);
        end
        next_cycle();
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'h0;
        #1;
        checks++; if (if_stall_req_o !== 1'b1 || inst_req_o !== 1'b0) begin
            errors++; $display("FAIL flush_relaunch got stall=%b req=%b want 1/0", if_stall_req_o, inst_req_o);
        end
        next_cycle();
        quiet_inputs();
        inst_addr_ok_i = 1'b1;
        #1;
        checks++; if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0000_0400) begin
            errors++; $display("FAIL flush_next_addr got req=%b addr=%h want 1/00000400", inst_req_o, inst_addr_o);
        end
        next_cycle();
        quiet_inputs();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h0000_0AAA;
        #1;
        checks++; if (if_instr_valid_o !== 1'b1 || if_instr_o !== 32'h0000_0AAA) begin
            errors++; $display("FAIL flush_next_data got valid=%b instr=%h want 1/00000aaa", if_instr_valid_o, if_instr_o);
        end
        next_cycle();
        quiet_inputs();
        $display("test_flush_data done");
    endtask

    task automatic test_flush_with_data();
        reach_data(32'h0000_0500);
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h5555_AAAA;
        if_flush_i     = 1'b1;
        #1;
        checks++; if (if_instr_valid_o !== 1'b0) begin errors++; $display("FAIL flush_same_cycle got %b want 0", if_instr_valid_o); end
        next_cycle();
        quiet_inputs();
        #1;
        checks++; if (if_instr_valid_o !== 1'b0 || if_stall_req_o !== 1'b0 || inst_req_o !== 1'b0) begin
            errors++; $display("FAIL flush_same_idle got valid=%b stall=%b req=%b want 0/0/0", if_instr_valid_o, if_stall_req_o, inst_req_o);
        end
        $display("test_flush_with_data done");
    endtask

    task automatic test_misaligned();
        if_req_i = 1'b1;
        if_pc_i  = 32'hBFC0_0002;
        #1;
        checks++; if (if_stall_req_o !== 1'b0 || if_instr_valid_o !== 1'b0 || if_instr_o !== 32'h0) begin
            errors++; $display("FAIL misaligned got stall=%b valid=%b instr=%h want 0/0/0", if_stall_req_o, if_instr_valid_o, if_instr_o);
        end
        next_cycle();
        #1;
        checks++; if (inst_req_o !== 1'b0) begin errors++; $display("FAIL misaligned_req got %b want 0", inst_req_o); end
        quiet_inputs();
        next_cycle();
        $display("test_misaligned done");
    endtask

    task automatic test_async_reset();
        if_req_i = 1'b1;
        if_pc_i  = 32'hBFC0_0000;
        next_cycle();
        quiet_inputs();
        #1;
        checks++; if (inst_req_o !== 1'b1) begin errors++; $display("FAIL areset_pre got %b want 1", inst_req_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (inst_req_o !== 1'b0 || if_stall_req_o !== 1'b0 || inst_addr_o !== 32'h0) begin
            errors++; $display("FAIL areset_now got req=%b stall=%b addr=%h want 0/0/0", inst_req_o, if_stall_req_o, inst_addr_o);
        end
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h2408_0001;
        #1;
        checks++; if (if_instr_valid_o !== 1'b0 || if_stall_req_o !== 1'b0) begin
            errors++; $display("FAIL areset_stray got valid=%b stall=%b want 0/0", if_instr_valid_o, if_stall_req_o);
        end
        next_cycle();
        quiet_inputs();
        #1;
        checks++; if (inst_req_o !== 1'b0 || if_instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL areset_after got req=%b valid=%b want 0/0", inst_req_o, if_instr_valid_o);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_addr_wait();
        test_hold();
        test_hold_flush();
        test_flush_data();
        test_flush_with_data();
        test_misaligned();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
